// File: rtl/mux_select_sequencer_pkg.sv
// rtl/mux_select_sequencer_pkg.sv - shared select codes, state enum and helpers for the mux select sequencer
package mux_select_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_CH0 = 3'd0,
      ST_CH1 = 3'd1,
      ST_CH2 = 3'd2,
      ST_CH3 = 3'd3,
      ST_CH4 = 3'd4,
      ST_CH5 = 3'd5,
      ST_ERR = 3'd6
   } state_t;

   // Select codes, identical to the case items of the display mux
   localparam logic [4:0] SEL_CH0 = 5'b00000;
   localparam logic [4:0] SEL_CH1 = 5'b00001;
   localparam logic [4:0] SEL_CH2 = 5'b00010;
   localparam logic [4:0] SEL_CH3 = 5'b00100;
   localparam logic [4:0] SEL_CH4 = 5'b01000;
   localparam logic [4:0] SEL_CH5 = 5'b10000;
   localparam logic [4:0] SEL_ERR = 5'b11111;

   localparam logic [2:0] ERR_CHANNEL = 3'd6;

   // Mux select code driven for a given state
   function automatic logic [4:0] sel_of(input state_t s);
      logic [4:0] code;
      case (s)
         ST_CH0:  code = SEL_CH0;
         ST_CH1:  code = SEL_CH1;
         ST_CH2:  code = SEL_CH2;
         ST_CH3:  code = SEL_CH3;
         ST_CH4:  code = SEL_CH4;
         ST_CH5:  code = SEL_CH5;
         default: code = SEL_ERR;
      endcase
      return code;
   endfunction

   // Channel that follows s in the scan order; CH5 wraps to CH0
   function automatic state_t next_ch(input state_t s);
      state_t n;
      case (s)
         ST_CH0:  n = ST_CH1;
         ST_CH1:  n = ST_CH2;
         ST_CH2:  n = ST_CH3;
         ST_CH3:  n = ST_CH4;
         ST_CH4:  n = ST_CH5;
         ST_CH5:  n = ST_CH0;
         default: n = ST_CH0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mux_select_sequencer_dwell_timer.sv
// rtl/mux_select_sequencer_dwell_timer.sv - dwell counter with clear, enable and terminal-count flag
module dwell_timer
   import mux_select_sequencer_pkg::*;
#(
   parameter int TW       = 16,
   parameter int TERMINAL = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [TW-1:0] count;

   // Clear dominates enable so an advance restarts the dwell from zero
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TW'(1);
      end
   end

   assign tc = (count == TW'(TERMINAL));

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - channel/error select sequencer with one-cycle-late mux data capture
module mux_select_sequencer
   import mux_select_sequencer_pkg::*;
#(
   parameter int DWELL_CYCLES = 8,
   parameter int TW           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       auto_en,
   input  logic       next_btn,
   input  logic       error_in,
   input  logic       error_clr,
   input  logic [7:0] data_in,
   output logic [4:0] select,
   output logic [2:0] channel,
   output logic [7:0] data_latched,
   output logic       sample_valid
);

   state_t state;
   state_t nxt;
   logic   pending;
   logic   in_ch;
   logic   tc;
   logic   advance;
   logic   tmr_en;
   logic   tmr_clr;

   assign in_ch   = (state != ST_ERR);
   assign advance = in_ch & (next_btn | (auto_en & tc));
   assign tmr_en  = in_ch & auto_en;
   // Timer only runs while auto-scanning a channel; any leave of that condition zeroes it
   assign tmr_clr = ~tmr_en | advance | error_in;

   dwell_timer #(
      .TW       (TW),
      .TERMINAL (DWELL_CYCLES - 1)
   ) u_dwell_timer (
      .clk (clk),
      .rst (rst),
      .clr (tmr_clr),
      .en  (tmr_en),
      .tc  (tc)
   );

   // Next state: fault beats advance; ERR is left only by a clear with the fault gone
   always_comb begin
      nxt = state;
      if (!in_ch) begin
         if (error_clr && !error_in) begin
            nxt = ST_CH0;
         end
      end else if (error_in) begin
         nxt = ST_ERR;
      end else if (advance) begin
         nxt = next_ch(state);
      end
   end

   // State, registered outputs and the sample latch that trails each select change by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_CH0;
         select       <= SEL_CH0;
         channel      <= 3'd0;
         data_latched <= 8'h00;
         sample_valid <= 1'b0;
         pending      <= 1'b1;
      end else begin
         state        <= nxt;
         select       <= sel_of(nxt);
         channel      <= (nxt == ST_ERR) ? ERR_CHANNEL : nxt;
         sample_valid <= pending;
         if (pending) begin
            data_latched <= data_in;
         end
         pending      <= (nxt != state);
      end
   end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - self-checking bench for the mux select sequencer
module tb_mux_select_sequencer;

   localparam int DW = 8;

   logic       clk;
   logic       rst;
   logic       auto_en;
   logic       next_btn;
   logic       error_in;
   logic       error_clr;
   logic [7:0] data_in;
   logic [4:0] select;
   logic [2:0] channel;
   logic [7:0] data_latched;
   logic       sample_valid;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_on   = 0;

   mux_select_sequencer #(
      .DWELL_CYCLES (DW),
      .TW           (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .auto_en      (auto_en),
      .next_btn     (next_btn),
      .error_in     (error_in),
      .error_clr    (error_clr),
      .data_in      (data_in),
      .select       (select),
      .channel      (channel),
      .data_latched (data_latched),
      .sample_valid (sample_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side display mux: seven inputs, each a distinct one-hot byte
   always_comb begin
      case (select)
         5'b00000: data_in = 8'h01;
         5'b00001: data_in = 8'h02;
         5'b00010: data_in = 8'h04;
         5'b00100: data_in = 8'h08;
         5'b01000: data_in = 8'h10;
         5'b10000: data_in = 8'h20;
         5'b11111: data_in = 8'h40;
         default:  data_in = 8'h00;
      endcase
   end

   function automatic logic [4:0] code_of(input int ch);
      if (ch == 6) return 5'b11111;
      if (ch == 0) return 5'b00000;
      return 5'(1 << (ch - 1));
   endfunction

   function automatic logic [7:0] byte_of(input int ch);
      if (ch == 6) return 8'h40;
      return 8'(1 << ch);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: channel index 0..5 or 6 for error, dwell count, pending sample
   int       m_ch, m_timer, prev;
   bit       m_pend, m_valid;
   logic [7:0] m_data;

   always @(posedge clk) begin
      if (rst) begin
         m_ch = 0; m_timer = 0; m_pend = 1; m_data = 8'h00; m_valid = 0;
      end else begin
         m_valid = m_pend;
         if (m_pend) m_data = byte_of(m_ch);
         m_pend = 0;
         prev = m_ch;
         if (m_ch == 6) begin
            if (error_clr && !error_in) m_ch = 0;
            m_timer = 0;
         end else if (error_in) begin
            m_ch = 6; m_timer = 0;
         end else if (!auto_en) begin
            m_timer = 0;
            if (next_btn) m_ch = (m_ch + 1) % 6;
         end else if (next_btn || m_timer == DW - 1) begin
            m_ch = (m_ch + 1) % 6; m_timer = 0;
         end else begin
            m_timer++;
         end
         if (m_ch != prev) m_pend = 1;
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_on) begin
         chk("cmp_select",  32'(select),       32'(code_of(m_ch)));
         chk("cmp_channel", 32'(channel),      32'(m_ch));
         chk("cmp_valid",   32'(sample_valid), 32'(m_valid));
         chk("cmp_data",    32'(data_latched), 32'(m_data));
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic pulse_next;
      next_btn = 1'b1; tick(); next_btn = 1'b0;
   endtask

   // Cycles until select changes, bounded
   task automatic wait_change(output int cnt);
      logic [4:0] s0;
      s0 = select;
      cnt = 0;
      do begin
         tick(); cnt++;
      end while (select == s0 && cnt < 30);
   endtask

   logic [4:0] sel_exp [6];
   logic [7:0] dat_exp [6];
   int         cnt;

   initial begin
      sel_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
      dat_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01};
      rst = 1'b1; auto_en = 1'b0; next_btn = 1'b0; error_in = 1'b0; error_clr = 1'b0;

      // Reset
      tick(); cmp_on = 1; tick();
      chk("rst_select", 32'(select), 32'h00);
      chk("rst_channel", 32'(channel), 32'h0);
      chk("rst_valid", 32'(sample_valid), 32'h0);
      chk("rst_data", 32'(data_latched), 32'h00);
      rst = 1'b0;
      tick();
      chk("first_select", 32'(select), 32'h00);
      chk("first_valid", 32'(sample_valid), 32'h1);
      chk("first_data", 32'(data_latched), 32'h01);
      tick();
      chk("first_valid_drop", 32'(sample_valid), 32'h0);

      // Manual stepping
      for (int i = 0; i < 6; i++) begin
         pulse_next();
         chk("man_select", 32'(select), 32'(sel_exp[i]));
         tick();
         chk("man_valid", 32'(sample_valid), 32'h1);
         chk("man_data", 32'(data_latched), 32'(dat_exp[i]));
         tick(); tick();
      end

      // Auto-scan: six dwells of DW cycles, ending back on CH0
      auto_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_change(cnt);
         chk("auto_dwell", 32'(cnt), 32'(DW));
         chk("auto_select", 32'(select), 32'(sel_exp[i]));
      end
      // Button at timer = 3 advances at once and restarts the dwell
      tick(); tick(); tick();
      pulse_next();
      chk("btn_mid_dwell", 32'(select), 32'h01);
      wait_change(cnt);
      chk("dwell_after_btn", 32'(cnt), 32'(DW));
      // Dropping auto_en mid-dwell clears the timer
      tick(); tick(); tick(); tick();
      auto_en = 1'b0; tick(); auto_en = 1'b1;
      wait_change(cnt);
      chk("dwell_after_pause", 32'(cnt), 32'(DW));
      chk("pause_select", 32'(select), 32'h04);
      auto_en = 1'b0;
      tick();

      // Error entry from CH2 together with a button pulse
      cnt = 0;
      while (select != 5'b00010 && cnt < 10) begin
         pulse_next(); tick(); cnt++;
      end
      chk("at_ch2", 32'(select), 32'h02);
      error_in = 1'b1; next_btn = 1'b1;
      tick();
      next_btn = 1'b0;
      chk("err_select", 32'(select), 32'h1f);
      chk("err_channel", 32'(channel), 32'h6);
      tick();
      chk("err_valid", 32'(sample_valid), 32'h1);
      chk("err_data", 32'(data_latched), 32'h40);
      pulse_next();
      chk("err_ignores_btn", 32'(select), 32'h1f);

      // Error exit
      error_clr = 1'b1; tick(); error_clr = 1'b0;
      chk("clr_while_err", 32'(select), 32'h1f);
      tick();
      error_in = 1'b0; tick();
      chk("no_clr_no_exit", 32'(select), 32'h1f);
      error_clr = 1'b1; tick(); error_clr = 1'b0;
      chk("exit_select", 32'(select), 32'h00);
      chk("exit_channel", 32'(channel), 32'h0);
      tick();
      chk("exit_valid", 32'(sample_valid), 32'h1);
      chk("exit_data", 32'(data_latched), 32'h01);

      // Reset mid-dwell in CH4
      for (int i = 0; i < 4; i++) begin
         pulse_next(); tick();
      end
      chk("at_ch4", 32'(select), 32'h08);
      auto_en = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1; tick();
      chk("mid_rst_select", 32'(select), 32'h00);
      chk("mid_rst_channel", 32'(channel), 32'h0);
      chk("mid_rst_valid", 32'(sample_valid), 32'h0);
      chk("mid_rst_data", 32'(data_latched), 32'h00);
      rst = 1'b0; auto_en = 1'b0; tick();
      chk("post_rst_valid", 32'(sample_valid), 32'h1);
      chk("post_rst_data", 32'(data_latched), 32'h01);

      // Reset while a sample is pending
      tick();
      pulse_next();
      rst = 1'b1; tick();
      chk("pend_rst_valid", 32'(sample_valid), 32'h0);
      chk("pend_rst_select", 32'(select), 32'h00);
      rst = 1'b0; tick();
      chk("pend_post_valid", 32'(sample_valid), 32'h1);
      chk("pend_post_data", 32'(data_latched), 32'h01);
      tick(); tick();

      cmp_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
